op_addsub: RTL and testbench

OP_ADDSUB -- requirements
Module: op_addsub

---
 rtl/op_pkg.sv | 48 ++++
 rtl/op_shifter.sv | 42 ++++
 rtl/op_addsub.sv | 147 ++++++++++++++
 tb/tb_op_addsub.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_pkg.sv
// Shared encodings for the add/subtract operation unit: operation codes,
// shift types, flag bundle and small decode helpers used by the adder stage.
package op_pkg;

   // Operation select carried on the op port.
   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_ADC = 2'b01,
      OP_SUB = 2'b10,
      OP_SBC = 2'b11
   } op_e;

   // Shift type carried on the stype port (ROR with amount 0 means RRX).
   typedef enum logic [1:0] {
      ST_LSL = 2'b00,
      ST_LSR = 2'b01,
      ST_ASR = 2'b10,
      ST_ROR = 2'b11
   } stype_e;

   // Condition flags travelling with an operation through the pipeline.
   typedef struct packed {
      logic c;
      logic z;
      logic n;
      logic v;
   } flags_t;

   // Subtracting operations feed the inverted operand into the adder.
   function automatic logic op_is_sub(input logic [1:0] op);
      return (op_e'(op) == OP_SUB) || (op_e'(op) == OP_SBC);
   endfunction

   // Adder carry-in: constant 0 for ADD, constant 1 for SUB (two's complement),
   // and the incoming carry flag for the with-carry forms.
   function automatic logic op_carry_in(input logic [1:0] op, input logic c);
      logic ci;
      case (op_e'(op))
         OP_ADD:  ci = 1'b0;
         OP_ADC:  ci = c;
         OP_SUB:  ci = 1'b1;
         OP_SBC:  ci = c;
         default: ci = 1'b0;
      endcase
      return ci;
   endfunction

endpackage

// File: rtl/op_shifter.sv
// Barrel shifter that forms the register form of operand2.
// Amount 0 has special meaning for LSR/ASR (shift by WIDTH) and ROR (RRX
// through the incoming carry). The shifter carry-out is not produced because
// the flags come from the adder only.
module op_shifter
   import op_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int SH_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] rm,
   input  logic [SH_W-1:0]  shamt,
   input  logic [1:0]       stype,
   input  logic             c_in,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] rot;

   // Select the shifted value according to shift type and the amount-0 rules.
   always_comb begin
      result = rm;
      rot    = rm;
      if (shamt != '0) begin
         rot = (rm >> shamt) | (rm << (WIDTH - int'(shamt)));
      end
      case (stype_e'(stype))
         ST_LSL: result = rm << shamt;
         ST_LSR: result = (shamt == '0) ? '0 : (rm >> shamt);
         ST_ASR: begin
            if (shamt == '0) begin
               result = {WIDTH{rm[WIDTH-1]}};
            end else begin
               result = $signed(rm) >>> shamt;
            end
         end
         ST_ROR: result = (shamt == '0) ? {c_in, rm[WIDTH-1:1]} : rot;
         default: result = rm;
      endcase
   end

endmodule

// File: rtl/op_addsub.sv
// Two-stage add/subtract unit with flag generation.
//   Stage 1: capture request, form operand2 (zero-extended immediate or
//            shifted register).
//   Stage 2: add/subtract, form rd and flags; this stage is the output register.
// Build option: define OP_ADDSUB_OVERFLOW_EN to compute V as signed overflow
// when s=1; otherwise v_out always returns the sampled v_in.
module op_addsub
   import op_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int IMM_W = 12,
   localparam int SH_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic             imm,
   input  logic             s,
   input  logic [WIDTH-1:0] rn,
   input  logic [WIDTH-1:0] rm,
   input  logic [IMM_W-1:0] imm_operand,
   input  logic [SH_W-1:0]  shamt,
   input  logic [1:0]       stype,
   input  logic             c_in,
   input  logic             z_in,
   input  logic             n_in,
   input  logic             v_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rd,
   output logic             c_out,
   output logic             z_out,
   output logic             n_out,
   output logic             v_out
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high. The producer keeps valid and its data stable until that edge;
   // ready may depend combinationally on downstream ready (in_ready follows
   // out_ready) but never on in_valid. out_valid/rd/flags hold while stalled.

   // Stage 1 registers
   logic             s1_valid;
   logic [1:0]       s1_op;
   logic             s1_s;
   logic [WIDTH-1:0] s1_rn;
   logic [WIDTH-1:0] s1_op2;
   flags_t           s1_flags;

   // Operand2 formation
   logic [WIDTH-1:0] shift_res;
   logic [WIDTH-1:0] op2_next;

   // Stage 2 datapath
   logic             s2_advance;
   logic [WIDTH-1:0] op2_eff;
   logic             carry_in;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sum_rd;
   flags_t           flags_next;

   op_shifter #(.WIDTH(WIDTH)) u_shifter (
      .rm     (rm),
      .shamt  (shamt),
      .stype  (stype),
      .c_in   (c_in),
      .result (shift_res)
   );

   // Accept whenever some stage can make room this cycle.
   assign in_ready   = !s1_valid || !out_valid || out_ready;
   assign s2_advance = !out_valid || out_ready;

   // Pick the immediate (zero-extended) or the shifted register as operand2.
   always_comb begin
      op2_next = shift_res;
      if (imm) begin
         op2_next = WIDTH'(imm_operand);
      end
   end

   // Stage 1 register: capture request fields and formed operand2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_s     <= 1'b0;
         s1_rn    <= '0;
         s1_op2   <= '0;
         s1_flags <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op    <= op;
            s1_s     <= s;
            s1_rn    <= rn;
            s1_op2   <= op2_next;
            s1_flags <= '{c: c_in, z: z_in, n: n_in, v: v_in};
         end
      end
   end

   // Adder and flag formation from the stage-1 contents.
   always_comb begin
      op2_eff  = op_is_sub(s1_op) ? ~s1_op2 : s1_op2;
      carry_in = op_carry_in(s1_op, s1_flags.c);
      sum      = {1'b0, s1_rn} + {1'b0, op2_eff} + {{WIDTH{1'b0}}, carry_in};
      sum_rd   = sum[WIDTH-1:0];

      flags_next = s1_flags;
      if (s1_s) begin
         flags_next.c = sum[WIDTH];
         flags_next.z = (sum_rd == '0);
         flags_next.n = sum_rd[WIDTH-1];
`ifdef OP_ADDSUB_OVERFLOW_EN
         flags_next.v = (s1_rn[WIDTH-1] == op2_eff[WIDTH-1]) &&
                        (sum_rd[WIDTH-1] != s1_rn[WIDTH-1]);
`else
         flags_next.v = s1_flags.v;
`endif
      end
   end

   // Stage 2 / output register: load when empty or when the consumer takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         rd        <= '0;
         c_out     <= 1'b0;
         z_out     <= 1'b0;
         n_out     <= 1'b0;
         v_out     <= 1'b0;
      end else if (s2_advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            rd    <= sum_rd;
            c_out <= flags_next.c;
            z_out <= flags_next.z;
            n_out <= flags_next.n;
            v_out <= flags_next.v;
         end
      end
   end

endmodule

// File: tb/tb_op_addsub.sv
// Self-checking bench for op_addsub (WIDTH=32, IMM_W=12). Honors
// OP_ADDSUB_OVERFLOW_EN when defined for the whole build.
module tb_op_addsub;

   localparam int WIDTH = 32;
   localparam int IMM_W = 12;
   localparam int SH_W  = 5;

   typedef struct packed {
      logic [1:0]       op;
      logic             imm;
      logic             s;
      logic [WIDTH-1:0] rn;
      logic [WIDTH-1:0] rm;
      logic [IMM_W-1:0] immop;
      logic [SH_W-1:0]  shamt;
      logic [1:0]       stype;
      logic             c;
      logic             z;
      logic             n;
      logic             v;
   } req_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       op = '0;
   logic             imm = 1'b0;
   logic             s = 1'b0;
   logic [WIDTH-1:0] rn = '0;
   logic [WIDTH-1:0] rm = '0;
   logic [IMM_W-1:0] imm_operand = '0;
   logic [SH_W-1:0]  shamt = '0;
   logic [1:0]       stype = '0;
   logic             c_in = 1'b0;
   logic             z_in = 1'b0;
   logic             n_in = 1'b0;
   logic             v_in = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] rd;
   logic             c_out;
   logic             z_out;
   logic             n_out;
   logic             v_out;

   // Result word layout: {rd, c, z, n, v}
   logic [WIDTH+3:0] exp_q[$];
   logic [WIDTH+3:0] obs_q[$];
   int vectors = 0;
   int miscompares = 0;

   op_addsub #(.WIDTH(WIDTH), .IMM_W(IMM_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .imm(imm), .s(s), .rn(rn), .rm(rm), .imm_operand(imm_operand),
      .shamt(shamt), .stype(stype), .c_in(c_in), .z_in(z_in), .n_in(n_in),
      .v_in(v_in), .out_valid(out_valid), .out_ready(out_ready), .rd(rd),
      .c_out(c_out), .z_out(z_out), .n_out(n_out), .v_out(v_out)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [WIDTH+3:0] model(input req_t r);
      logic [WIDTH-1:0] op2;
      logic [WIDTH-1:0] rdv;
      longint unsigned  a, b, t;
      longint           sa, sb, ss, sh, lim;
      int               k, cin, brw;
      logic             cf, zf, nf, vf, ovf;
      if (r.imm) begin
         op2 = {20'd0, r.immop};
      end else begin
         case (r.stype)
            2'd0: op2 = r.rm << r.shamt;
            2'd1: op2 = (r.shamt == 0) ? 32'd0 : (r.rm >> r.shamt);
            2'd2: begin
               sh  = longint'($signed(r.rm));
               k   = (r.shamt == 0) ? 32 : int'(r.shamt);
               op2 = 32'(sh >>> k);
            end
            default: begin
               if (r.shamt == 0) begin
                  op2 = {r.c, r.rm[31:1]};
               end else begin
                  op2 = r.rm;
                  for (int i = 0; i < int'(r.shamt); i++) op2 = {op2[0], op2[31:1]};
               end
            end
         endcase
      end
      a   = {32'd0, r.rn};
      b   = {32'd0, op2};
      sa  = longint'($signed(r.rn));
      sb  = longint'($signed(op2));
      cin = r.c ? 1 : 0;
      brw = r.c ? 0 : 1;
      case (r.op)
         2'd0: begin t = a + b;       cf = t[32];                     ss = sa + sb;       end
         2'd1: begin t = a + b + cin; cf = t[32];                     ss = sa + sb + cin; end
         2'd2: begin t = a - b;       cf = (a >= b);                  ss = sa - sb;       end
         default: begin t = a - b - brw; cf = (a >= b + longint'(brw)); ss = sa - sb - brw; end
      endcase
      rdv = t[31:0];
      lim = 64'sd2147483648;
      ovf = (ss >= lim) || (ss < -lim);
      zf  = (rdv == 0);
      nf  = rdv[31];
`ifdef OP_ADDSUB_OVERFLOW_EN
      vf = ovf;
`else
      vf = r.v;
`endif
      if (!r.s) begin
         cf = r.c; zf = r.z; nf = r.n; vf = r.v;
      end
      return {rdv, cf, zf, nf, vf};
   endfunction

   function automatic req_t mk(input logic [1:0] o, input logic im, input logic sf,
                               input logic [31:0] a, input logic [31:0] m,
                               input logic [11:0] io, input logic [4:0] sa,
                               input logic [1:0] st, input logic [3:0] f);
      req_t r;
      r.op = o; r.imm = im; r.s = sf; r.rn = a; r.rm = m; r.immop = io;
      r.shamt = sa; r.stype = st; {r.c, r.z, r.n, r.v} = f;
      return r;
   endfunction

   function automatic logic [31:0] pick_word();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.op    = 2'($urandom_range(0, 3));
      r.imm   = 1'($urandom_range(0, 1));
      r.s     = ($urandom_range(0, 3) != 0);
      r.rn    = pick_word();
      r.rm    = pick_word();
      r.immop = 12'($urandom);
      r.shamt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r.stype = 2'($urandom_range(0, 3));
      {r.c, r.z, r.n, r.v} = 4'($urandom);
      return r;
   endfunction

   // ---------------- driver tasks (start and end at posedge+1) ----------------
   task automatic send(input req_t r);
      bit acc = 0;
      int tries = 0;
      op = r.op; imm = r.imm; s = r.s; rn = r.rn; rm = r.rm; imm_operand = r.immop;
      shamt = r.shamt; stype = r.stype; {c_in, z_in, n_in, v_in} = {r.c, r.z, r.n, r.v};
      in_valid = 1'b1;
      while (!acc && tries < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         tries++;
      end
      in_valid = 1'b0;
      if (acc) begin
         exp_q.push_back(model(r));
      end else begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: in_ready low for %0d cycles, required accept", tries);
      end
   endtask

   task automatic collect(input int n, input int budget, input bit rand_ready, output int cycles);
      int got = 0;
      cycles = 0;
      while (got < n && cycles < budget) begin
         out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         if (out_valid && out_ready) begin
            obs_q.push_back({rd, c_out, z_out, n_out, v_out});
            got++;
         end
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({out_valid, rd, c_out, z_out, n_out, v_out} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got valid=%b rd=%h flags=%b%b%b%b, required all 0",
                  out_valid, rd, c_out, z_out, n_out, v_out);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      req_t r[$];
      logic [WIDTH+3:0] lit[$];
      int cyc;
      exp_q.delete(); obs_q.delete();
      r.push_back(mk(2'd0, 1, 1, 32'hFFFF_FFFF, 32'h0, 12'd1, 5'd0, 2'd0, 4'b0000));
      lit.push_back({32'h0000_0000, 4'b1100});
      r.push_back(mk(2'd2, 0, 1, 32'd5, 32'd7, 12'd0, 5'd0, 2'd0, 4'b0000));
      lit.push_back({32'hFFFF_FFFE, 4'b0010});
      r.push_back(mk(2'd0, 0, 0, 32'd0, 32'h8000_0001, 12'd0, 5'd0, 2'd2, 4'b0000));
      lit.push_back({32'hFFFF_FFFF, 4'b0000});
      r.push_back(mk(2'd0, 0, 0, 32'd0, 32'h8000_0001, 12'd0, 5'd0, 2'd3, 4'b1000));
      lit.push_back({32'hC000_0000, 4'b1000});
      r.push_back(mk(2'd3, 0, 0, 32'd100, 32'd30, 12'd0, 5'd0, 2'd0, 4'b1111));
      lit.push_back({32'd70, 4'b1111});
`ifdef OP_ADDSUB_OVERFLOW_EN
      r.push_back(mk(2'd0, 0, 1, 32'h7FFF_FFFF, 32'd1, 12'd0, 5'd0, 2'd0, 4'b0000));
      lit.push_back({32'h8000_0000, 4'b0011});
`else
      r.push_back(mk(2'd1, 1, 1, 32'hFFFF_FFFE, 32'd0, 12'd1, 5'd0, 2'd0, 4'b1001));
      lit.push_back({32'h0000_0000, 4'b1101});
`endif
      fork
         begin
            foreach (r[i]) send(r[i]);
         end
         collect(r.size(), 100, 1'b0, cyc);
      join
      vectors++;
      if (obs_q.size() != lit.size()) begin
         miscompares++;
         $display("FAIL directed_count: got %0d results, required %0d", obs_q.size(), lit.size());
      end
      foreach (lit[i]) begin
         if (i < obs_q.size()) begin
            vectors++;
            if (obs_q[i] !== lit[i]) begin
               miscompares++;
               $display("FAIL directed_%0d: got rd=%h cznv=%b, required rd=%h cznv=%b",
                        i, obs_q[i][35:4], obs_q[i][3:0], lit[i][35:4], lit[i][3:0]);
            end
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL directed_model_%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      exp_q.delete(); obs_q.delete();
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 16; i++) send(rand_req());
         end
         collect(16, 60, 1'b0, cyc);
      join
      vectors++;
      if (cyc != 18) begin
         miscompares++;
         $display("FAIL b2b_throughput: got %0d cycles for 16 results, required 18", cyc);
      end
      vectors++;
      if (obs_q.size() != 16) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d, required 16", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL b2b_%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      req_t r[4];
      int accepted = 0;
      int cyc;
      bit held_ok = 1;
      exp_q.delete(); obs_q.delete();
      for (int i = 0; i < 4; i++)
         r[i] = mk(2'd0, 1, 0, 32'd0, 32'd0, 12'(i + 1), 5'd0, 2'd0, 4'b0000);
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         op = r[accepted].op; imm = 1'b1; s = 1'b0; rn = 32'd0;
         imm_operand = r[accepted].immop; {c_in, z_in, n_in, v_in} = 4'b0000;
         in_valid = 1'b1;
         @(negedge clk);
         if (c >= 3 && (!out_valid || rd !== 32'd1)) held_ok = 0;
         if (in_ready) begin
            exp_q.push_back(model(r[accepted]));
            accepted++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      vectors++;
      if (accepted != 2) begin
         miscompares++;
         $display("FAIL bp_accepts: got %0d accepts under stall, required 2", accepted);
      end
      vectors++;
      if (!held_ok) begin
         miscompares++;
         $display("FAIL bp_hold: got valid=%b rd=%h during stall, required valid=1 rd=1", out_valid, rd);
      end
      fork
         begin
            for (int i = accepted; i < 4; i++) send(r[i]);
         end
         collect(4, 60, 1'b0, cyc);
      join
      vectors++;
      if (obs_q.size() != 4) begin
         miscompares++;
         $display("FAIL bp_count: got %0d, required 4", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < 4; i++) begin
         vectors++;
         if (obs_q[i][35:4] !== 32'(i + 1)) begin
            miscompares++;
            $display("FAIL bp_order_%0d: got rd=%h, required %h", i, obs_q[i][35:4], i + 1);
         end
      end
   endtask

   task automatic test_random();
      int cyc;
      exp_q.delete(); obs_q.delete();
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send(rand_req());
               if ($urandom_range(0, 4) == 0) begin
                  @(posedge clk); #1;
               end
            end
         end
         collect(300, 3000, 1'b1, cyc);
      join
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL rand_count: got %0d, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL rand_%0d: got rd=%h cznv=%b, required rd=%h cznv=%b",
                     i, obs_q[i][35:4], obs_q[i][3:0], exp_q[i][35:4], exp_q[i][3:0]);
         end
      end
   endtask

   task automatic test_reset_inflight();
      bit leaked = 0;
      exp_q.delete(); obs_q.delete();
      out_ready = 1'b0;
      send(rand_req());
      send(rand_req());
      vectors++;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL rip_loaded: got out_valid=%b before reset, required 1", out_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({out_valid, rd, c_out, z_out, n_out, v_out} !== '0) begin
         miscompares++;
         $display("FAIL rip_async_clear: got valid=%b rd=%h, required valid=0 rd=0", out_valid, rd);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rip_in_ready: got %b, required 1", in_ready);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) leaked = 1;
         @(posedge clk); #1;
      end
      vectors++;
      if (leaked) begin
         miscompares++;
         $display("FAIL rip_no_result: got out_valid=1 after reset, required 0");
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
